fifo_drain: RTL and testbench
=============================

# fifo_drain

Downstream consumer for the 8-deep, 32-bit synchronous FIFO. On a `start` pulse, `fifo_drain` pops exactly `len` words through the FIFO's read port. It stalls while the FIFO reports empty and captures each word on the cycle the FIFO acknowledges it. It accumulates a modulo-2^32 sum and a running XOR, then pulses `done`. It sits between the FIFO read side and the block that consumes checksummed bursts.

## Interface
Parameters:
- `DW`, 32: data width; must equal the FIFO data width.
- `LW`, 8: width of `len` and `word_cnt`; maximum burst is 2^LW−1 words.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: begin a burst; sampled only in IDLE.
- `len`  in  LW: number of words to pop; sampled with `start`.
- `empty`  in  1: FIFO empty flag.
- `rd_ack`  in  1: FIFO read acknowledge; `d_out` is valid in the same cycle.
- `rd_err`  in  1: FIFO read error; the read was refused.
- `d_out`  in  DW: FIFO registered read data.
- `rd_en`  out  1: read request to the FIFO.
- `busy`  out  1: high in READ and DONE.
- `done`  out  1: one-cycle completion pulse.
- `sum`  out  DW: modulo-2^DW sum of the captured words.
- `xsum`  out  DW: XOR of the captured words.
- `word_cnt`  out  LW: number of words captured in the current burst.
- `err`  out  1: sticky protocol error for the current burst.

## Operation
The FSM has three states; the reset state is IDLE.
- IDLE: when `start`=1, latch `len`, clear `sum`, `xsum`, `word_cnt`, `err`, `issued` and `pending`.
  - If `len`=0, go to DONE.
  - Otherwise go to READ.
- READ: issue reads and capture data as described below.
  - Go to DONE on the edge where a capture makes `word_cnt`==`len`.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.

Read issue (READ state):
- `rd_en` = READ && !`empty` && (`issued` < `len`).
- `rd_en` is combinational from registered state and the FIFO's `empty` flag.
- `issued` increments on every cycle where `rd_en`=1.
- `pending` is a register: it is set to 1 if `rd_en` was asserted in the previous cycle, and 0 otherwise.

Capture (READ state):
- If `pending` && `rd_ack`: `sum`+=`d_out` (carry discarded), `xsum`^=`d_out`, `word_cnt`+=1.
- If `pending` && `rd_err`: set `err`=1 and decrement `issued` so the word is re-requested. Nothing is captured.
- `rd_ack` or `rd_err` arriving while `pending`=0 sets `err`=1 and is otherwise ignored.

Output holding and sampling rules:
- `sum`, `xsum`, `word_cnt` and `err` hold their values after DONE until the next accepted `start`.
- `start` is ignored in READ and DONE.
- `len` is not resampled mid-burst.

## Timing
- Reset values: state=IDLE, `rd_en`=0, `busy`=0, `done`=0, `sum`=0, `xsum`=0, `word_cnt`=0, `err`=0. Internal `issued`=0, `pending`=0.
- Reset asserted mid-burst aborts immediately and returns all outputs to their reset values. FIFO contents are not restored.
- Read latency is 1 cycle: `rd_en` in cycle t gives `rd_ack` and valid `d_out` in cycle t+1.
- Back-to-back reads are allowed: `rd_en` may be high every cycle while the FIFO is not empty.
- Best-case latency with no stalls: with `start` sampled in cycle 0, `rd_en` is high in cycles 1..`len`, the last capture occurs at the end of cycle `len`+1, and `done` is high in cycle `len`+2.
- `len`=0: `done` is high in cycle 1 and `rd_en` is never asserted.
- Empty stall: `rd_en` drops in the same cycle `empty` rises and resumes in the first cycle `empty`=0. There is no extra bubble.
- The FIFO drops to empty after the last word is popped: `rd_en` was already issued, so the capture still completes in the following cycle.
- A capture and a new `rd_en` can occur in the same cycle.
- `issued` never exceeds `len`, so no over-read is possible.

## Structure
- Package `fifo_drain_pkg` holds:
  - state encoding localparams: IDLE=2'b00, READ=2'b01, DONE=2'b10;
  - default `DW`/`LW` constants.
- Single flat module with no sub-module.
- Registers use asynchronous active-low reset flip-flops.
- Expected size is about 150 lines of RTL.

## Test plan
- Basic burst: FIFO preloaded with 1,2,3; `start` with `len`=3. Required: `rd_en` high in cycles 1–3, `sum`=6, `xsum`=0, `word_cnt`=3, `done` in cycle 5, `err`=0.
- Stall: FIFO holds 1 word (0xA); `start` with `len`=2; push 0xB four cycles later. Required: `rd_en` low while `empty`=1, then `sum`=0x15, `xsum`=0x1, `done` one cycle after the second capture.
- Wrap and full depth: preload 8 words of 0xFFFFFFFF; `len`=8. Required: `sum`=0xFFFFFFF8, `xsum`=0, FIFO ends empty, `done` in cycle 10.
- `len`=0, and `start` while busy. Required:
  - `len`=0: `done` in cycle 1, `sum`=0, no `rd_en`.
  - A second `start` during READ is ignored and `len` is unchanged.
- Error and reset: inject `rd_ack` while `pending`=0, which requires `err`=1 for the rest of the burst with `sum` unaffected. Then assert `reset_n`=0 mid-burst, which requires all outputs to be 0 immediately and the FSM to be in IDLE after release.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared types and default sizing for the FIFO drain block.
package fifo_drain_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned LW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fifo_drain.sv
// FIFO read-side consumer: pops a burst of len words, accumulating a
// modulo-2^DW sum and running XOR, then pulses done for one cycle.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          empty,
  input  logic          rd_ack,
  input  logic          rd_err,
  input  logic [DW-1:0] d_out,
  output logic          rd_en,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic [DW-1:0] xsum,
  output logic [LW-1:0] word_cnt,
  output logic          err
);

  state_t        r_state;
  state_t        w_next;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_issued;
  logic          r_pending;
  logic [DW-1:0] r_sum;
  logic [DW-1:0] r_xsum;
  logic [LW-1:0] r_cnt;
  logic          r_err;

  logic          w_in_read;
  logic          w_rd_en;
  logic          w_cap;
  logic          w_retry;
  logic          w_err_set;
  logic [LW-1:0] w_cnt_inc;

  assign w_in_read = (r_state == READ);
  assign w_cnt_inc = r_cnt + 1'b1;

  // An acknowledged read captures; a refused read (without ack) is re-requested.
  assign w_cap     = w_in_read && r_pending && rd_ack;
  assign w_retry   = w_in_read && r_pending && rd_err && !rd_ack;
  assign w_err_set = w_in_read && ((r_pending && rd_err) ||
                                   (!r_pending && (rd_ack || rd_err)));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = (len == '0) ? DONE : READ;
      READ:    if (w_cap && (w_cnt_inc == r_len)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state; read request also gated by the FIFO empty flag.
  always_comb begin
    w_rd_en = w_in_read && !empty && (r_issued < r_len);
    busy    = (r_state == READ) || (r_state == DONE);
    done    = (r_state == DONE);
  end

  // Burst datapath: length latch, issue tracking, accumulators and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len     <= '0;
      r_issued  <= '0;
      r_pending <= 1'b0;
      r_sum     <= '0;
      r_xsum    <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_rd_en;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_len     <= len;
            r_issued  <= '0;
            r_pending <= 1'b0;
            r_sum     <= '0;
            r_xsum    <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
          end
        end
        READ: begin
          if (w_cap) begin
            r_sum  <= r_sum + d_out;
            r_xsum <= r_xsum ^ d_out;
            r_cnt  <= w_cnt_inc;
          end
          if (w_err_set) r_err <= 1'b1;
          // A new issue and a retry in the same cycle cancel out.
          unique case ({w_rd_en, w_retry})
            2'b10:   r_issued <= r_issued + 1'b1;
            2'b01:   r_issued <= r_issued - 1'b1;
            default: r_issued <= r_issued;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign rd_en    = w_rd_en;
  assign sum      = r_sum;
  assign xsum     = r_xsum;
  assign word_cnt = r_cnt;
  assign err      = r_err;

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain with a behavioural 1-cycle-latency FIFO.
module tb_fifo_drain;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic [LW-1:0] len     = '0;
  logic          empty   = 1'b1;
  logic          f_ack   = 1'b0;
  logic          f_err   = 1'b0;
  logic          inj_ack = 1'b0;
  logic [DW-1:0] f_dout  = '0;
  logic          rd_ack;
  logic          rd_err;
  logic          rd_en;
  logic          busy;
  logic          done;
  logic [DW-1:0] sum;
  logic [DW-1:0] xsum;
  logic [LW-1:0] word_cnt;
  logic          err;

  logic          push_req = 1'b0;
  logic [DW-1:0] push_dat = '0;
  logic [DW-1:0] fq[$];

  typedef struct {
    logic [DW-1:0] sum;
    logic [DW-1:0] xsum;
    logic [LW-1:0] cnt;
    logic          err;
  } exp_t;

  logic [DW-1:0] model_q[$];
  exp_t          sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  assign rd_ack = f_ack | inj_ack;
  assign rd_err = f_err;

  fifo_drain #(.DW(DW), .LW(LW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .len      (len),
    .empty    (empty),
    .rd_ack   (rd_ack),
    .rd_err   (rd_err),
    .d_out    (f_dout),
    .rd_en    (rd_en),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .xsum     (xsum),
    .word_cnt (word_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data and ack one cycle after rd_en.
  always @(posedge clk) begin
    f_ack <= 1'b0;
    f_err <= 1'b0;
    if (rd_en) begin
      if (fq.size() > 0) begin
        f_dout <= fq.pop_front();
        f_ack  <= 1'b1;
      end else begin
        f_err <= 1'b1;
      end
    end
    if (push_req) fq.push_back(push_dat);
    empty <= (fq.size() == 0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    @(negedge clk);
    push_req = 1'b1;
    push_dat = d;
    model_q.push_back(d);
    @(negedge clk);
    push_req = 1'b0;
  endtask

  // Called at a negedge; that cycle is cycle 0 (start sampled at its end).
  task automatic burst(input int L, input int push_cyc, input logic [DW-1:0] push_val,
                       input int start_cyc, input int inj_cyc, input logic exp_err,
                       input int exp_done, input logic [63:0] exp_mask);
    exp_t          e;
    exp_t          got_e;
    logic [63:0]   mask;
    logic [DW-1:0] w;
    int            dcyc;
    if (push_cyc >= 0) model_q.push_back(push_val);
    e.sum  = '0;
    e.xsum = '0;
    e.cnt  = L[LW-1:0];
    e.err  = exp_err;
    for (int i = 0; i < L; i++) begin
      w      = model_q.pop_front();
      e.sum  = e.sum + w;
      e.xsum = e.xsum ^ w;
    end
    sb.push_back(e);
    start = 1'b1;
    len   = L[LW-1:0];
    mask  = '0;
    dcyc  = -1;
    for (int c = 1; c <= 100 && dcyc < 0; c++) begin
      @(negedge clk);
      start    = (c == start_cyc);
      if (c == start_cyc) len = 8'd1;
      inj_ack  = (c == inj_cyc);
      push_req = (c == push_cyc);
      push_dat = push_val;
      if (c == 1) check("busy_c1", 64'(busy), 64'd1);
      if (inj_cyc >= 0 && c == inj_cyc + 1) check("err_mid", 64'(err), 64'd1);
      if (c < 64 && rd_en) mask[c] = 1'b1;
      if (done) dcyc = c;
    end
    start    = 1'b0;
    inj_ack  = 1'b0;
    push_req = 1'b0;
    check("done_cycle", 64'(dcyc), 64'(exp_done));
    check("rd_en_cycles", mask, exp_mask);
    got_e = sb.pop_front();
    check("sum", 64'(sum), 64'(got_e.sum));
    check("xsum", 64'(xsum), 64'(got_e.xsum));
    check("word_cnt", 64'(word_cnt), 64'(got_e.cnt));
    check("err", 64'(err), 64'(got_e.err));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("sum_hold", 64'(sum), 64'(got_e.sum));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_xsum"}, 64'(xsum), 64'd0);
    check({tag, "_cnt"}, 64'(word_cnt), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] w;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic burst 1,2,3.
    push_word(32'd1); push_word(32'd2); push_word(32'd3);
    burst(3, -1, '0, -1, -1, 1'b0, 5, 64'hE);

    // Empty stall: one word present, second pushed mid-burst.
    push_word(32'hA);
    burst(2, 4, 32'hB, -1, -1, 1'b0, 7, 64'h22);

    // Full depth with sum wraparound.
    for (int i = 0; i < 8; i++) push_word(32'hFFFF_FFFF);
    burst(8, -1, '0, -1, -1, 1'b0, 10, 64'h1FE);
    check("fifo_empty", 64'(empty), 64'd1);

    // Zero-length burst.
    burst(0, -1, '0, -1, -1, 1'b0, 1, 64'h0);

    // Second start with a different len during READ must be ignored.
    push_word(32'd4); push_word(32'd5); push_word(32'd6);
    burst(3, -1, '0, 2, -1, 1'b0, 5, 64'hE);
    check("fifo_empty2", 64'(empty), 64'd1);

    // Stray ack while nothing is pending.
    push_word(32'h5);
    burst(2, 5, 32'h7, -1, 3, 1'b1, 8, 64'h42);

    // Reset asserted mid-burst while stalled.
    push_word(32'h9);
    w = model_q.pop_front();
    start = 1'b1;
    len   = 8'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_sum", 64'(sum), 64'(w));
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_rd_en", 64'(rd_en), 64'd0);

    // Recovery burst after reset.
    push_word(32'h33);
    burst(1, -1, '0, -1, -1, 1'b0, 3, 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
